// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute redirect
// and the decode-stage handoff. The fetch unit is the master side.
interface if_fetch_queue_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response
// queue to decode, and redirect handling that flushes and drops wrong-path words.
module if_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_queue_if.master bus
);
  localparam int              PTRW    = $clog2(DEPTH);
  localparam int              CNTW    = PTRW + 1;
  localparam logic [CNTW:0]   DEPTH_W = (CNTW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] out_q, out_d;
  logic [CNTW-1:0] drop_q, drop_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;

  logic            req_valid;
  logic            req_fire;
  logic            rsp_eff;
  logic            push;
  logic            pop;
  logic            id_valid;
  logic [XLEN-1:0] redir_pc;

  // Every accepted request is guaranteed a queue slot, so responses never overflow.
  always_comb begin
    redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
    req_valid = !rst && !bus.redirect_valid &&
                (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_W);
    req_fire  = req_valid && bus.imem_req_ready;
    rsp_eff   = bus.imem_rsp_valid && (out_q != '0);
    push      = rsp_eff && (drop_q == '0) && !bus.redirect_valid;
    id_valid  = (count_q != '0) && !bus.redirect_valid;
    pop       = id_valid && bus.id_ready;
  end

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CNTW'(req_fire) - CNTW'(rsp_eff);

    if (bus.redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      // Everything still in flight after this cycle is wrong-path, including
      // requests already marked for dropping by an earlier redirect.
      drop_d     = out_q - CNTW'(rsp_eff);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (rsp_eff && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: bus.imem_rsp_data, pc: resp_pc_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
        resp_pc_d       = resp_pc_q + PC_STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_instr       = (count_q != '0) ? mem_q[rd_ptr_q].instr : '0;
  assign bus.id_pc          = (count_q != '0) ? mem_q[rd_ptr_q].pc    : '0;
endmodule
